// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, FSM states and ALU control encodings for mips_multicycle
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE,
    ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP
  } state_t;

  // slt follows the sign of the raw difference, matching the single-cycle ALU
  function automatic logic [31:0] alu(input logic [2:0] ctl, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] diff;
    diff = a - b;
    case (ctl)
      ALU_SUB: return diff;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'd0, diff[31]};
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_fsm.sv
// rtl/mips_mc_fsm.sv - multicycle control FSM; bne decode enabled by MIPS_MC_BNE_EN
module mips_mc_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       irwrite,
  output logic       datawrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       branch_ne,
  output logic [1:0] pcsrc,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       aluoutwrite,
  output logic       trap
);

  state_t state, state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    datawrite   = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    branch_ne   = (op == OP_BNE);
    pcsrc       = 2'b00;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    alucontrol  = ALU_ADD;
    aluoutwrite = 1'b0;
    trap        = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        alusrcb     = 2'b11;
        aluoutwrite = 1'b1;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_next = BRANCH;
`endif
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default:      state_next = TRAP;
        endcase
      end
      MEMADR, ADDIEX: begin
        alusrca     = 1'b1;
        alusrcb     = 2'b10;
        aluoutwrite = 1'b1;
        if (state == ADDIEX)   state_next = ADDIWB;
        else if (op == OP_LW)  state_next = MEMREAD;
        else                   state_next = MEMWRITE;
      end
      MEMREAD: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        datawrite = mem_ready;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      EXECUTE: begin
        alusrca     = 1'b1;
        aluoutwrite = 1'b1;
        state_next  = ALUWB;
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: begin
            aluoutwrite = 1'b0;
            state_next  = TRAP;
          end
        endcase
      end
      ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        state_next = FETCH;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        branch     = 1'b1;
        pcsrc      = 2'b01;
        state_next = FETCH;
      end
      JUMP: begin
        pcwrite    = 1'b1;
        pcsrc      = 2'b10;
        state_next = FETCH;
      end
      TRAP:    trap = 1'b1;
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: rtl/mips_multicycle.sv
// rtl/mips_multicycle.sv - multicycle MIPS core, one shared memory port; bne via MIPS_MC_BNE_EN
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          REG_INIT_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_out,
  output logic        trap
);

  logic [31:0] pc, ir, data_reg, a_reg, b_reg, aluout;
  logic [31:0] rd1, rd2, srca, srcb, alu_y, imm_ext, pc_next, wd, addr_mux;
  logic [31:0] rf [0:31];
  logic [4:0]  wa;
  logic        req_c, iord, irwrite, datawrite, pcwrite, branch, branch_ne;
  logic        regwrite, regdst, memtoreg, alusrca, aluoutwrite, zero, pc_en;
  logic [1:0]  pcsrc, alusrcb;
  logic [2:0]  alucontrol;

  mips_mc_fsm u_fsm (
    .clk(clk), .reset(reset), .op(ir[31:26]), .funct(ir[5:0]), .mem_ready(mem_ready),
    .mem_req(req_c), .mem_we(mem_we), .iord(iord), .irwrite(irwrite),
    .datawrite(datawrite), .pcwrite(pcwrite), .branch(branch), .branch_ne(branch_ne),
    .pcsrc(pcsrc), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .aluoutwrite(aluoutwrite), .trap(trap)
  );

  assign imm_ext = {{16{ir[15]}}, ir[15:0]};
  assign rd1     = (ir[25:21] == 5'd0) ? 32'd0 : rf[ir[25:21]];
  assign rd2     = (ir[20:16] == 5'd0) ? 32'd0 : rf[ir[20:16]];
  assign wa      = regdst ? ir[15:11] : ir[20:16];
  assign wd      = memtoreg ? data_reg : aluout;
  assign srca    = alusrca ? a_reg : pc;

  always_comb begin
    case (alusrcb)
      2'b00:   srcb = b_reg;
      2'b01:   srcb = 32'd4;
      2'b10:   srcb = imm_ext;
      default: srcb = {imm_ext[29:0], 2'b00};
    endcase
  end

  assign alu_y = alu(alucontrol, srca, srcb);
  assign zero  = (alu_y == 32'd0);

  always_comb begin
    case (pcsrc)
      2'b01:   pc_next = aluout;
      2'b10:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      default: pc_next = alu_y;
    endcase
  end

  // branch_ne flips the equality test so one BRANCH state serves beq and bne
  assign pc_en     = pcwrite | (branch & (zero ^ branch_ne));
  assign addr_mux  = iord ? aluout : pc;
  assign mem_addr  = addr_mux & ~32'd3;
  assign mem_wdata = b_reg;
  assign mem_req   = req_c & ~reset;
  assign pc_out    = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= '0;
      data_reg <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      aluout   <= '0;
    end else begin
      if (pc_en)       pc       <= pc_next;
      if (irwrite)     ir       <= mem_rdata;
      if (datawrite)   data_reg <= mem_rdata;
      if (aluoutwrite) aluout   <= alu_y;
      a_reg <= rd1;
      b_reg <= rd2;
    end
  end

  generate
    if (REG_INIT_ZERO) begin : g_rf_rst
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (regwrite && wa != 5'd0) begin
          rf[wa] <= wd;
        end
      end
    end else begin : g_rf
      always_ff @(posedge clk) begin
        if (regwrite && wa != 5'd0) rf[wa] <= wd;
      end
    end
  endgenerate

endmodule

// File: tb/tb_mips_multicycle.sv
// tb/tb_mips_multicycle.sv - self-checking bench for mips_multicycle (bne checks follow MIPS_MC_BNE_EN)
`timescale 1ns/1ps
module tb_mips_multicycle;

  localparam logic [5:0] T_ADDI = 6'b001000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_J = 6'b000010;

  typedef struct {
    int          tid;
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } acc_t;

  logic        clk = 1'b0, reset = 1'b1, mem_ready = 1'b1;
  logic        mem_req, mem_we, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [31:0] mem [0:63];
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we, busy = 1'b0;
  int          n_checks = 0, n_fail = 0, cyc = 0, stall_n = 0, wait_cnt = 0, n_writes = 0, w0;
  acc_t        vec [$];
  acc_t        exp_q [$];
  acc_t        e;

  mips_multicycle #(.RESET_PC(32'h0000_0000), .REG_INIT_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_out(pc_out), .trap(trap)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[7:2]];

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check1(string name, logic got, logic exp);
    check(name, {31'd0, got}, {31'd0, exp});
  endtask

  task automatic add(int tid, int c, logic [31:0] a, logic we, logic [31:0] d);
    acc_t r;
    r.tid = tid; r.cyc = c; r.addr = a; r.we = we; r.wdata = d;
    vec.push_back(r);
  endtask

  // Memory responder and access scoreboard, evaluated on the falling edge
  initial forever begin
    @(negedge clk);
    if (reset) begin
      cyc = 0; busy = 1'b0; wait_cnt = 0; mem_ready = 1'b1;
    end else begin
      if (mem_req) begin
        if (!busy) begin
          busy = 1'b1; wait_cnt = 0;
          cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("acc_cycle", cyc, e.cyc);
            check("acc_addr", mem_addr, e.addr);
            check1("acc_we", mem_we, e.we);
            if (e.we) check("acc_wdata", mem_wdata, e.wdata);
          end
        end else begin
          check("stall_addr", mem_addr, cap_addr);
          check1("stall_we", mem_we, cap_we);
          if (cap_we) check("stall_wdata", mem_wdata, cap_wdata);
        end
        if (wait_cnt < stall_n) begin
          mem_ready = 1'b0; wait_cnt++;
        end else begin
          mem_ready = 1'b1; busy = 1'b0;
          if (mem_we) begin
            mem[mem_addr[7:2]] = mem_wdata; n_writes++;
          end
        end
      end else begin
        busy = 1'b0; mem_ready = 1'b1;
      end
      cyc++;
    end
  end

  task automatic hold_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    foreach (mem[i]) mem[i] = 32'd0;
  endtask

  task automatic release_reset(int tid, int s);
    stall_n = s;
    exp_q.delete();
    foreach (vec[i]) if (vec[i].tid == tid) exp_q.push_back(vec[i]);
    @(posedge clk); #1;
    check1("rst_mem_req", mem_req, 1'b0);
    check("rst_pc", pc_out, 32'h0);
    check1("rst_trap", trap, 1'b0);
    reset = 1'b0;
  endtask

  task automatic wait_done(string name);
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 300) begin @(posedge clk); g++; end
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic goto_cycle(int n);
    int g;
    g = 0;
    while (cyc < n && g < 300) begin @(posedge clk); g++; end
    #1;
    check1("cycle_reached", cyc >= n, 1'b1);
  endtask

  task automatic load_prog_a();
    mem[0] = enc_i(T_ADDI, 5'd0, 5'd2, 16'd5);
    mem[1] = enc_i(T_ADDI, 5'd0, 5'd3, 16'd12);
    mem[2] = {6'd0, 5'd2, 5'd3, 5'd4, 5'd0, 6'b100000};
    mem[3] = enc_i(T_SW, 5'd0, 5'd4, 16'd84);
  endtask

  initial begin
    // zero-wait program: retire every 4 cycles, store 17 at 84
    add(1, 0, 32'h00, 1'b0, 0); add(1, 4, 32'h04, 1'b0, 0); add(1, 8, 32'h08, 1'b0, 0);
    add(1, 12, 32'h0C, 1'b0, 0); add(1, 15, 32'd84, 1'b1, 32'd17); add(1, 16, 32'h10, 1'b0, 0);
    // same program with two wait states per access
    add(2, 0, 32'h00, 1'b0, 0); add(2, 6, 32'h04, 1'b0, 0); add(2, 12, 32'h08, 1'b0, 0);
    add(2, 18, 32'h0C, 1'b0, 0); add(2, 23, 32'd84, 1'b1, 32'd17); add(2, 26, 32'h10, 1'b0, 0);
    // beq taken, beq not taken, j 0x10, sw $2,88
    add(3, 0, 32'h00, 1'b0, 0); add(3, 4, 32'h04, 1'b0, 0); add(3, 7, 32'h10, 1'b0, 0);
    add(3, 10, 32'h14, 1'b0, 0); add(3, 13, 32'h40, 1'b0, 0); add(3, 16, 32'd88, 1'b1, 32'd5);
    add(3, 17, 32'h44, 1'b0, 0);
    // lw/sw round trip through 0x50
    add(4, 0, 32'h00, 1'b0, 0); add(4, 3, 32'h60, 1'b0, 0); add(4, 5, 32'h04, 1'b0, 0);
    add(4, 8, 32'h50, 1'b1, 32'hDEADBEEF); add(4, 9, 32'h08, 1'b0, 0); add(4, 12, 32'h50, 1'b0, 0);
    add(4, 14, 32'h0C, 1'b0, 0); add(4, 17, 32'd84, 1'b1, 32'hDEADBEEF); add(4, 18, 32'h10, 1'b0, 0);
    add(5, 0, 32'h00, 1'b0, 0);
    add(6, 0, 32'h00, 1'b0, 0);
    add(8, 0, 32'h00, 1'b0, 0); add(8, 9, 32'h04, 1'b0, 0); add(8, 17, 32'd84, 1'b1, 32'd5);
    add(9, 0, 32'h00, 1'b0, 0); add(9, 4, 32'h04, 1'b0, 0); add(9, 7, 32'd84, 1'b1, 32'd5);
    add(10, 0, 32'h00, 1'b0, 0); add(10, 4, 32'h04, 1'b0, 0); add(10, 8, 32'h08, 1'b0, 0);
`ifdef MIPS_MC_BNE_EN
    add(10, 11, 32'h10, 1'b0, 0); add(10, 14, 32'd84, 1'b1, 32'd12); add(10, 15, 32'h14, 1'b0, 0);
`endif

    hold_reset(); load_prog_a(); release_reset(1, 0);
    wait_done("t1_done");
    check("t1_mem84", mem[21], 32'd17);

    hold_reset(); load_prog_a(); release_reset(2, 2);
    wait_done("t2_done");
    check("t2_mem84", mem[21], 32'd17);

    hold_reset();
    mem[0]  = enc_i(T_ADDI, 5'd0, 5'd2, 16'd5);
    mem[1]  = enc_i(T_BEQ, 5'd2, 5'd2, 16'd2);
    mem[2]  = enc_i(T_SW, 5'd0, 5'd2, 16'd84);
    mem[3]  = enc_i(T_SW, 5'd0, 5'd2, 16'd84);
    mem[4]  = enc_i(T_BEQ, 5'd2, 5'd3, 16'd5);
    mem[5]  = {T_J, 26'h10};
    mem[16] = enc_i(T_SW, 5'd0, 5'd2, 16'd88);
    release_reset(3, 0);
    wait_done("t3_done");
    check("t3_no_skipped_store", mem[21], 32'd0);

    hold_reset();
    mem[24] = 32'hDEADBEEF;
    mem[0]  = enc_i(T_LW, 5'd0, 5'd6, 16'h60);
    mem[1]  = enc_i(T_SW, 5'd0, 5'd6, 16'h50);
    mem[2]  = enc_i(T_LW, 5'd0, 5'd5, 16'h50);
    mem[3]  = enc_i(T_SW, 5'd0, 5'd5, 16'd84);
    release_reset(4, 0);
    wait_done("t4_done");

    // illegal opcode: trap after DECODE, then a quiet port
    hold_reset();
    mem[0] = enc_i(6'b111111, 5'd0, 5'd0, 16'd0);
    release_reset(5, 0);
    wait_done("t5_done");
    goto_cycle(1); check1("t5_trap_decode", trap, 1'b0);
    goto_cycle(2); check1("t5_trap_set", trap, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check1("t5_req_quiet", mem_req, 1'b0);
      @(posedge clk); #1;
    end
    check("t5_pc_frozen", pc_out, 32'h4);
    check1("t5_trap_sticky", trap, 1'b1);

    // refetch after trap; cleared word 0 is an R-type with an unknown funct
    hold_reset();
    release_reset(6, 0);
    wait_done("t6_done");
    goto_cycle(2); check1("t6_trap_execute", trap, 1'b0);
    goto_cycle(3); check1("t6_trap_funct", trap, 1'b1);

    // reset lands in the middle of a stalled store
    hold_reset();
    mem[21] = 32'h1234_5678;
    mem[0]  = enc_i(T_ADDI, 5'd0, 5'd2, 16'd5);
    mem[1]  = enc_i(T_SW, 5'd0, 5'd2, 16'd84);
    w0 = n_writes;
    release_reset(8, 5);
    wait_done("t8_done");
    goto_cycle(19);
    check1("t8_stalled", mem_ready, 1'b0);
    reset = 1'b1;
    #1 check1("t8_req_drop", mem_req, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t8_no_write", n_writes, w0);
    check("t8_mem_kept", mem[21], 32'h1234_5678);
    release_reset(9, 0);
    wait_done("t9_done");
    check("t9_mem84", mem[21], 32'd5);

    hold_reset();
    mem[0] = enc_i(T_ADDI, 5'd0, 5'd2, 16'd5);
    mem[1] = enc_i(T_ADDI, 5'd0, 5'd3, 16'd12);
    mem[2] = enc_i(T_BNE, 5'd2, 5'd3, 16'd1);
    mem[3] = enc_i(T_SW, 5'd0, 5'd2, 16'd84);
    mem[4] = enc_i(T_SW, 5'd0, 5'd3, 16'd84);
    release_reset(10, 0);
    wait_done("t10_done");
    goto_cycle(12);
`ifdef MIPS_MC_BNE_EN
    check1("t10_bne_no_trap", trap, 1'b0);
`else
    check1("t10_bne_trap", trap, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
